// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, derived sync windows and the
// 3-3-2 colour layout shared by the VGA sync generator and its interface.
package vga_timing_pkg;

  // Counter width for x/y
  localparam int unsigned CW = 11;

  // Default horizontal timing (pixels)
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  // Default vertical timing (lines)
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Sync pulse windows, start inclusive / end exclusive
  localparam int unsigned HSYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned HSYNC_END   = HSYNC_START + DEF_H_SYNC;
  localparam int unsigned VSYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned VSYNC_END   = VSYNC_START + DEF_V_SYNC;

  // Colour field positions inside the 8-bit renderer word
  localparam int unsigned R_MSB = 7;
  localparam int unsigned R_LSB = 5;
  localparam int unsigned G_MSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_MSB = 1;
  localparam int unsigned B_LSB = 0;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: scan position / sync / colour bundle between the sync
// generator (master) and the renderer plus pin side (slave).
//   rgb_in      renderer colour for the current x/y
//   x, y        scan position
//   hsync/vsync active-low sync, video_on visible-area flag
//   pixel_tick  pixel-rate enable, frame_start wrap pulse
//   vga_r/g/b   blanked colour pins
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic [7:0]    rgb_in;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          pixel_tick;
  logic          frame_start;
  logic [2:0]    vga_r;
  logic [2:0]    vga_g;
  logic [1:0]    vga_b;

  modport master (
    input  rgb_in,
    output x, y, hsync, vsync, video_on, pixel_tick, frame_start,
    output vga_r, vga_g, vga_b
  );

  modport slave (
    output rgb_in,
    input  x, y, hsync, vsync, video_on, pixel_tick, frame_start,
    input  vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV into a registered one-clk enable.
//   clk, reset  system clock, synchronous active-high reset
//   tick        high in the clk where the divider sits at CLK_DIV-1
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;

  // Wrap at CLK_DIV-1; for CLK_DIV=1 this holds at 0 and tick stays high
  always_comb begin
    div_next = (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
  end

  // tick is registered from the next count so it lines up with div_cnt==LAST
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      tick    <= (div_next == LAST);
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing and blanked 3-3-2 colour pins.
//   clk, reset  system clock, synchronous active-high reset
//   bus         vga_sync_gen_if.master: rgb_in in; x, y, hsync, vsync,
//               video_on, pixel_tick, frame_start, vga_r/g/b out
// Build option VGA_SYNC_ALIGN_EN: delays hsync/vsync/video_on by two clks
// so the sync edges line up with the colour pins.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master bus
);
  localparam int unsigned H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic          tick;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          wrap_c;
  logic          hs_c;
  logic          vs_c;
  logic          von_c;
  logic          hs_r;
  logic          vs_r;
  logic          von_r;
  rgb332_t       pix_c;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign bus.pixel_tick = tick;

  // Next scan position; x advances at the end of each pixel period
  always_comb begin
    x_next = bus.x;
    y_next = bus.y;
    wrap_c = 1'b0;
    if (tick) begin
      if (bus.x == CW'(H_TOT - 1)) begin
        x_next = '0;
        if (bus.y == CW'(V_TOT - 1)) begin
          y_next = '0;
          wrap_c = 1'b1;
        end else begin
          y_next = bus.y + CW'(1);
        end
      end else begin
        x_next = bus.x + CW'(1);
      end
    end
  end

  // Decode from the next position so the registered flags match x/y
  always_comb begin
    hs_c  = !((x_next >= CW'(HS_START)) && (x_next < CW'(HS_END)));
    vs_c  = !((y_next >= CW'(VS_START)) && (y_next < CW'(VS_END)));
    von_c = (x_next < CW'(H_DISPLAY)) && (y_next < CW'(V_DISPLAY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.x           <= '0;
      bus.y           <= '0;
      bus.frame_start <= 1'b0;
      hs_r            <= 1'b1;
      vs_r            <= 1'b1;
      von_r           <= 1'b0;
    end else begin
      bus.x           <= x_next;
      bus.y           <= y_next;
      bus.frame_start <= wrap_c;
      hs_r            <= hs_c;
      vs_r            <= vs_c;
      von_r           <= von_c;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  // Two-stage delay matching renderer + colour register latency
  logic [1:0] hs_d;
  logic [1:0] vs_d;
  logic [1:0] von_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d  <= 2'b11;
      vs_d  <= 2'b11;
      von_d <= 2'b00;
    end else begin
      hs_d  <= {hs_d[0], hs_r};
      vs_d  <= {vs_d[0], vs_r};
      von_d <= {von_d[0], von_r};
    end
  end

  assign bus.hsync    = hs_d[1];
  assign bus.vsync    = vs_d[1];
  assign bus.video_on = von_d[1];
`else
  assign bus.hsync    = hs_r;
  assign bus.vsync    = vs_r;
  assign bus.video_on = von_r;
`endif

  always_comb begin
    pix_c = '{r: bus.rgb_in[R_MSB:R_LSB],
              g: bus.rgb_in[G_MSB:G_LSB],
              b: bus.rgb_in[B_MSB:B_LSB]};
  end

  // Colour pins: rgb_in only passes while video_on is high
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
    end else if (bus.video_on) begin
      bus.vga_r <= pix_c.r;
      bus.vga_g <= pix_c.g;
      bus.vga_b <= pix_c.b;
    end else begin
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of the VGA sync generator.
// dut0 runs the full 800-pixel line at CLK_DIV=2 with a shortened vertical
// timing (6 visible lines, vsync on lines 8..9, 13 lines per frame) so whole
// frames fit in a short run; dut1 runs CLK_DIV=1.
module tb_vga_sync_gen;
`ifdef VGA_SYNC_ALIGN_EN
  localparam int ALIGN = 1;
`else
  localparam int ALIGN = 0;
`endif

  logic clk;
  logic reset;

  vga_sync_gen_if bus0 ();
  vga_sync_gen_if bus1 ();

  vga_sync_gen #(
    .CLK_DIV(2), .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.master)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int prev_x, prev_y, prev_hs, prev_vs, prev_x1;
  int w1, w2, x656, hs_fall, hs_rise;
  int vs_fall, vs_rise, vs_y;
  int fs1, fs2, fs_count, bad_fs;
  int line_cnt, lines_checked, bad_lines, lines_started;
  int bad_pin, exp_r, exp_g, exp_b;
  int w1a, w1b, bad_t1;
  int found;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus0.rgb_in = 8'hFF;
    bus1.rgb_in = 8'h00;
    repeat (3) step();

    // Reset state
    check("rst_x", 32'(bus0.x), 0);
    check("rst_y", 32'(bus0.y), 0);
    check("rst_hsync", 32'(bus0.hsync), 1);
    check("rst_vsync", 32'(bus0.vsync), 1);
    check("rst_video_on", 32'(bus0.video_on), 0);
    check("rst_pixel_tick", 32'(bus0.pixel_tick), 0);
    check("rst_frame_start", 32'(bus0.frame_start), 0);
    check("rst_vga_r", 32'(bus0.vga_r), 0);
    check("rst_vga_g", 32'(bus0.vga_g), 0);
    check("rst_vga_b", 32'(bus0.vga_b), 0);
    check("rst_tick_div1", 32'(bus1.pixel_tick), 0);

    // Release: first tick lands in the second clk after the last reset edge
    reset = 1'b0;
    cyc = 0;
    step();
    check("rel1_tick", 32'(bus0.pixel_tick), 1);
    check("rel1_x", 32'(bus0.x), 0);
    check("rel1_frame_start", 32'(bus0.frame_start), 0);
    check("rel1_video_on", 32'(bus0.video_on), (ALIGN != 0) ? 0 : 1);
    check("rel1_tick_div1", 32'(bus1.pixel_tick), 1);
    check("rel1_x_div1", 32'(bus1.x), 0);
    step();
    check("rel2_tick", 32'(bus0.pixel_tick), 0);
    check("rel2_x", 32'(bus0.x), 1);
    check("rel2_frame_start", 32'(bus0.frame_start), 0);
    check("rel2_tick_div1", 32'(bus1.pixel_tick), 1);
    check("rel2_x_div1", 32'(bus1.x), 1);

    // Free run for two frames while gathering timing observations
    prev_x = int'(bus0.x); prev_y = int'(bus0.y);
    prev_hs = int'(bus0.hsync); prev_vs = int'(bus0.vsync);
    prev_x1 = int'(bus1.x);
    w1 = -1; w2 = -1; x656 = -1; hs_fall = -1; hs_rise = -1;
    vs_fall = -1; vs_rise = -1; vs_y = -1;
    fs1 = -1; fs2 = -1; fs_count = 0; bad_fs = 0;
    line_cnt = 0; lines_checked = 0; bad_lines = 0; lines_started = 0;
    bad_pin = 0; exp_r = 7; exp_g = 7; exp_b = 3;
    w1a = -1; w1b = -1; bad_t1 = 0;

    for (int i = 0; i < 41708; i++) begin
      step();
      // line wrap / per-line visible clk count
      if (prev_x == 799 && bus0.x == 0) begin
        if (w1 < 0) w1 = cyc; else if (w2 < 0) w2 = cyc;
        if (lines_started != 0) begin
          lines_checked++;
          if (line_cnt != ((prev_y < 6) ? 1280 : 0)) bad_lines++;
        end
        lines_started = 1;
        line_cnt = 0;
      end
      if (bus0.video_on) line_cnt++;
      // hsync window
      if (x656 < 0 && prev_x == 655 && bus0.x == 656) x656 = cyc;
      if (hs_fall < 0 && prev_hs == 1 && bus0.hsync == 1'b0) hs_fall = cyc;
      if (hs_fall >= 0 && hs_rise < 0 && prev_hs == 0 && bus0.hsync == 1'b1) hs_rise = cyc;
      // vsync window
      if (vs_fall < 0 && prev_vs == 1 && bus0.vsync == 1'b0) begin
        vs_fall = cyc;
        vs_y = int'(bus0.y);
      end
      if (vs_fall >= 0 && vs_rise < 0 && prev_vs == 0 && bus0.vsync == 1'b1) vs_rise = cyc;
      // frame_start only on the wrap to (0,0); second frame uses a new colour
      if (bus0.frame_start) begin
        fs_count++;
        if (fs1 < 0) begin
          fs1 = cyc;
          bus0.rgb_in = 8'hAE;
          exp_r = 5; exp_g = 3; exp_b = 2;
        end else if (fs2 < 0) begin
          fs2 = cyc;
        end
        if (!(bus0.x == 0 && bus0.y == 0 && prev_x == 799 && prev_y == 12)) bad_fs++;
      end
      // colour pins: pass-through when visible, zero when blanked
      if (bus0.x >= 8 && bus0.x <= 630 && bus0.y < 6) begin
        if (!(int'(bus0.vga_r) == exp_r && int'(bus0.vga_g) == exp_g &&
              int'(bus0.vga_b) == exp_b && bus0.video_on)) bad_pin++;
      end else if (bus0.x >= 645 || bus0.y >= 6) begin
        if (bus0.vga_r != 0 || bus0.vga_g != 0 || bus0.vga_b != 0 || bus0.video_on) bad_pin++;
      end
      // CLK_DIV=1 instance
      if (!bus1.pixel_tick) bad_t1++;
      if (prev_x1 == 799 && bus1.x == 0) begin
        if (w1a < 0) w1a = cyc; else if (w1b < 0) w1b = cyc;
      end
      prev_x = int'(bus0.x); prev_y = int'(bus0.y);
      prev_hs = int'(bus0.hsync); prev_vs = int'(bus0.vsync);
      prev_x1 = int'(bus1.x);
    end

    check("first_line_wrap", 32'(w1), 1600);
    check("line_period", 32'(w2 - w1), 1600);
    check("hsync_low_clks", 32'(hs_rise - hs_fall), 192);
    check("hsync_fall_vs_x656", 32'(hs_fall - x656), 32'(2 * ALIGN));
    check("vsync_low_clks", 32'(vs_rise - vs_fall), 3200);
    check("vsync_fall_y", 32'(vs_y), 8);
    check("first_frame_start", 32'(fs1), 20800);
    check("frame_period", 32'(fs2 - fs1), 20800);
    check("frame_start_count", 32'(fs_count), 2);
    check("frame_start_position", 32'(bad_fs), 0);
    check("lines_checked", 32'(lines_checked), 25);
    check("video_on_per_line", 32'(bad_lines), 0);
    check("colour_pins", 32'(bad_pin), 0);
    check("div1_tick_every_clk", 32'(bad_t1), 0);
    check("div1_line_period", 32'(w1b - w1a), 800);

    // Mid-frame reset at x=300 on a vsync line
    found = 0;
    for (int i = 0; i < 30000 && found == 0; i++) begin
      step();
      if (bus0.x == 300 && bus0.y == 8) found = 1;
    end
    check("find_x300_y8", 32'(found), 1);
    check("pre_reset_vsync", 32'(bus0.vsync), 0);
    reset = 1'b1;
    step();
    check("mid_rst_x", 32'(bus0.x), 0);
    check("mid_rst_y", 32'(bus0.y), 0);
    check("mid_rst_hsync", 32'(bus0.hsync), 1);
    check("mid_rst_vsync", 32'(bus0.vsync), 1);
    check("mid_rst_video_on", 32'(bus0.video_on), 0);
    check("mid_rst_frame_start", 32'(bus0.frame_start), 0);
    reset = 1'b0;
    step();
    check("resume1_tick", 32'(bus0.pixel_tick), 1);
    check("resume1_frame_start", 32'(bus0.frame_start), 0);
    step();
    check("resume2_x", 32'(bus0.x), 1);
    step();
    step();
    check("resume4_x", 32'(bus0.x), 2);
    check("resume4_y", 32'(bus0.y), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
